// File: rtl/stage_id_regread.sv
// Decode-side register read: 8-entry register file with WB write port, same-cycle
// WB-to-ID bypass, load-use hazard detection and the ID/EX pipeline register.
module stage_id_regread #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_final,
    input  logic [ADDR_W-1:0] rd_final,
    input  logic [DATA_W-1:0] write_data_WB,
    input  logic              valid_ID,
    input  logic [ADDR_W-1:0] rs1_ID,
    input  logic [ADDR_W-1:0] rs2_ID,
    input  logic              uses_rs1_ID,
    input  logic              uses_rs2_ID,
    input  logic [ADDR_W-1:0] rd_ID,
    input  logic              RegWrite_ID,
    input  logic              ResultSrc_ID,
    input  logic              MemWrite_ID,
    input  logic [3:0]        alu_op_ID,
    input  logic              flush_ID,
    output logic              stall_ID,
    output logic              valid_EX,
    output logic [DATA_W-1:0] rs1_data_EX,
    output logic [DATA_W-1:0] rs2_data_EX,
    output logic [ADDR_W-1:0] rs1_EX,
    output logic [ADDR_W-1:0] rs2_EX,
    output logic [ADDR_W-1:0] rd_EX,
    output logic              RegWrite_EX,
    output logic              ResultSrc_EX,
    output logic              MemWrite_EX,
    output logic [3:0]        alu_op_EX,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic              valid_q,        valid_d;
    logic [DATA_W-1:0] rs1_data_q,     rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q,     rs2_data_d;
    logic [ADDR_W-1:0] rs1_q,          rs1_d;
    logic [ADDR_W-1:0] rs2_q,          rs2_d;
    logic [ADDR_W-1:0] rd_q,           rd_d;
    logic              reg_write_q,    reg_write_d;
    logic              result_src_q,   result_src_d;
    logic              mem_write_q,    mem_write_d;
    logic [3:0]        alu_op_q,       alu_op_d;
    logic [CNT_W-1:0]  stall_count_q,  stall_count_d;

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              wb_write_en;
    logic              haz;

    assign wb_write_en = RegWrite_final && !(ZERO_REG && (rd_final == '0));

    // Register file next state: one write port, the ignored-R0 case handled above.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (wb_write_en && (rd_final == ADDR_W'(gi))) begin
                    regs_d[gi] = write_data_WB;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    // Read ports bypass the value being written this same edge.
    always_comb begin
        rs1_val = regs_q[rs1_ID];
        if (ZERO_REG && (rs1_ID == '0)) begin
            rs1_val = '0;
        end else if (RegWrite_final && (rd_final == rs1_ID)) begin
            rs1_val = write_data_WB;
        end

        rs2_val = regs_q[rs2_ID];
        if (ZERO_REG && (rs2_ID == '0)) begin
            rs2_val = '0;
        end else if (RegWrite_final && (rd_final == rs2_ID)) begin
            rs2_val = write_data_WB;
        end
    end

    always_comb begin
        haz = valid_ID && valid_q && reg_write_q && result_src_q
              && !(ZERO_REG && (rd_q == '0))
              && ((uses_rs1_ID && (rs1_ID == rd_q)) || (uses_rs2_ID && (rs2_ID == rd_q)));
        stall_ID = haz && !flush_ID;
    end

    always_comb begin
        valid_d       = 1'b0;
        rs1_data_d    = '0;
        rs2_data_d    = '0;
        rs1_d         = '0;
        rs2_d         = '0;
        rd_d          = '0;
        reg_write_d   = 1'b0;
        result_src_d  = 1'b0;
        mem_write_d   = 1'b0;
        alu_op_d      = '0;
        stall_count_d = stall_count_q;

        // Flush and stall both leave the all-zero bubble set by the defaults.
        if (!flush_ID && !stall_ID) begin
            valid_d      = valid_ID;
            rs1_data_d   = rs1_val;
            rs2_data_d   = rs2_val;
            rs1_d        = rs1_ID;
            rs2_d        = rs2_ID;
            rd_d         = rd_ID;
            reg_write_d  = RegWrite_ID  && valid_ID;
            result_src_d = ResultSrc_ID && valid_ID;
            mem_write_d  = MemWrite_ID  && valid_ID;
            alu_op_d     = alu_op_ID;
        end

        if (stall_ID && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            result_src_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            alu_op_q      <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            result_src_q  <= result_src_d;
            mem_write_q   <= mem_write_d;
            alu_op_q      <= alu_op_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign valid_EX     = valid_q;
    assign rs1_data_EX  = rs1_data_q;
    assign rs2_data_EX  = rs2_data_q;
    assign rs1_EX       = rs1_q;
    assign rs2_EX       = rs2_q;
    assign rd_EX        = rd_q;
    assign RegWrite_EX  = reg_write_q;
    assign ResultSrc_EX = result_src_q;
    assign MemWrite_EX  = mem_write_q;
    assign alu_op_EX    = alu_op_q;
    assign stall_count  = stall_count_q;

endmodule
